// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard control for the 16-bit 5-stage pipeline.
// A shadow pipeline of destination tags picks the youngest in-flight producer for each EX operand.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [2:0]        sel_a,
  output logic [2:0]        sel_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [2:0] {
    SEL_RF  = 3'd0,
    SEL_EXM = 3'd1,
    SEL_MWB = 3'd2,
    SEL_WBR = 3'd3,
    SEL_IMM = 3'd4
  } sel_e;

  // The load flag only matters while the producer sits in EX, so later slots drop it.
  logic              ex_v_q,  ex_we_q, ex_ld_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              mem_v_q, mem_we_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              wb_v_q,  wb_we_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic              ex_valid_q;
  sel_e              sel_a_q, sel_b_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  sel_e              sel_a_d, sel_b_d;
  logic              ex_hit_a, ex_hit_b;
  logic              issue;

  function automatic logic slot_match(input logic v, input logic we,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] r);
    return v && we && (rd == r) && (r != '0);
  endfunction

  function automatic sel_e pick_src(input logic used, input logic [REG_AW-1:0] r,
                                    input logic ex_v, input logic ex_we, input logic [REG_AW-1:0] ex_rd,
                                    input logic mem_v, input logic mem_we, input logic [REG_AW-1:0] mem_rd,
                                    input logic wb_v, input logic wb_we, input logic [REG_AW-1:0] wb_rd);
    if (!used || r == '0)                       return SEL_RF;
    else if (slot_match(ex_v, ex_we, ex_rd, r))    return SEL_EXM;
    else if (slot_match(mem_v, mem_we, mem_rd, r)) return SEL_MWB;
    else if (slot_match(wb_v, wb_we, wb_rd, r))    return SEL_WBR;
    else                                           return SEL_RF;
  endfunction

  always_comb begin
    ex_hit_a = id_rs_used && slot_match(ex_v_q, ex_we_q, ex_rd_q, id_rs);
    ex_hit_b = id_rt_used && slot_match(ex_v_q, ex_we_q, ex_rd_q, id_rt);
    stall    = id_valid && !flush && ex_ld_q && (ex_hit_a || ex_hit_b);
    issue    = id_valid && !flush && !stall;
    sel_a_d  = pick_src(id_rs_used, id_rs, ex_v_q, ex_we_q, ex_rd_q,
                        mem_v_q, mem_we_q, mem_rd_q, wb_v_q, wb_we_q, wb_rd_q);
    sel_b_d  = id_use_imm ? SEL_IMM :
               pick_src(id_rt_used, id_rt, ex_v_q, ex_we_q, ex_rd_q,
                        mem_v_q, mem_we_q, mem_rd_q, wb_v_q, wb_we_q, wb_rd_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_v_q      <= 1'b0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_rd_q     <= '0;
      mem_v_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_rd_q    <= '0;
      wb_v_q      <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      ex_valid_q  <= 1'b0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
    end else begin
      wb_v_q   <= mem_v_q;
      wb_we_q  <= mem_we_q;
      wb_rd_q  <= mem_rd_q;
      mem_v_q  <= ex_v_q;
      mem_we_q <= ex_we_q;
      mem_rd_q <= ex_rd_q;
      if (issue) begin
        ex_v_q     <= 1'b1;
        ex_rd_q    <= id_rd;
        ex_we_q    <= id_wr_en;
        ex_ld_q    <= id_is_load;
        ex_valid_q <= 1'b1;
        sel_a_q    <= sel_a_d;
        sel_b_q    <= sel_b_d;
      end else begin
        // Bubble: clearing we/ld too keeps a dead slot from ever matching or stalling.
        ex_v_q     <= 1'b0;
        ex_we_q    <= 1'b0;
        ex_ld_q    <= 1'b0;
        ex_valid_q <= 1'b0;
        sel_a_q    <= SEL_RF;
        sel_b_q    <= SEL_RF;
      end
      if (stall && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign sel_a     = sel_a_q;
  assign sel_b     = sel_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit; counter width is shrunk to exercise saturation.
module tb_fwd_hazard_unit;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_rs_used, id_rt_used, id_use_imm, id_wr_en, id_is_load, flush;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          stall, ex_valid;
  logic [2:0]    sel_a, sel_b;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] exp_cnt;

  fwd_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_use_imm(id_use_imm),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .sel_a(sel_a), .sel_b(sel_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic rsu, input logic rtu, input logic imm,
                       input logic [AW-1:0] rd, input logic we, input logic ld, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_use_imm = imm; id_rd = rd; id_wr_en = we; id_is_load = ld; flush = fl;
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), 1, 1, 0,
            $urandom_range(0, 15), 1, 1, 0);
      tick();
    end
    n_cmp++; if (sel_a !== 3'd0) begin n_bad++; $display("FAIL reset_sel_a got=%0d exp=0", sel_a); end
    n_cmp++; if (sel_b !== 3'd0) begin n_bad++; $display("FAIL reset_sel_b got=%0d exp=0", sel_b); end
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    rst_n = 1'b1;
    exp_cnt = '0;
    idle(3);
  endtask

  task automatic test_fwd_distance();
    logic [2:0] exp_sel [4];
    exp_sel[0] = 3'd1; exp_sel[1] = 3'd2; exp_sel[2] = 3'd3; exp_sel[3] = 3'd0;
    drive(1, 1, 1, 0, 0, 0, 3, 1, 0, 0);  // ADD r3
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 7, 1, 0, 0, 9, 0, 0, 0);
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fwd_dist_stall[%0d] got=%b exp=0", i, stall); end
      tick();
      n_cmp++; if (sel_a !== exp_sel[i]) begin n_bad++; $display("FAIL fwd_dist_sel_a[%0d] got=%0d exp=%0d", i, sel_a, exp_sel[i]); end
      n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL fwd_dist_ex_valid[%0d] got=%b exp=1", i, ex_valid); end
    end
    idle(3);
  endtask

  task automatic test_priority();
    drive(1, 0, 0, 0, 0, 0, 5, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 5, 1, 0, 0); tick();
    drive(1, 5, 5, 1, 1, 0, 1, 0, 0, 0); tick();
    n_cmp++; if (sel_a !== 3'd1) begin n_bad++; $display("FAIL prio_youngest_a got=%0d exp=1", sel_a); end
    n_cmp++; if (sel_b !== 3'd1) begin n_bad++; $display("FAIL prio_youngest_b got=%0d exp=1", sel_b); end
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();  // producer r0
    drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 0); tick();
    n_cmp++; if (sel_a !== 3'd0) begin n_bad++; $display("FAIL r0_sel_a got=%0d exp=0", sel_a); end
    n_cmp++; if (sel_b !== 3'd0) begin n_bad++; $display("FAIL r0_sel_b got=%0d exp=0", sel_b); end
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 6, 1, 0, 0); tick();
    drive(1, 6, 6, 1, 1, 1, 1, 0, 0, 0); tick();
    n_cmp++; if (sel_b !== 3'd4) begin n_bad++; $display("FAIL imm_sel_b got=%0d exp=4", sel_b); end
    n_cmp++; if (sel_a !== 3'd1) begin n_bad++; $display("FAIL imm_sel_a got=%0d exp=1", sel_a); end
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 8, 1, 0, 0); tick();
    drive(1, 8, 8, 0, 0, 0, 1, 0, 0, 0); tick();
    n_cmp++; if (sel_a !== 3'd0) begin n_bad++; $display("FAIL unused_sel_a got=%0d exp=0", sel_a); end
    idle(3);
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 0, 2, 1, 1, 0); tick();  // LOAD r2
    drive(1, 1, 2, 0, 1, 0, 7, 1, 0, 0);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ld_use_stall got=%b exp=1", stall); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL ld_use_bubble got=%b exp=0", ex_valid); end
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_bad++; $display("FAIL ld_use_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ld_use_one_cycle got=%b exp=0", stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL ld_use_issue got=%b exp=1", ex_valid); end
    n_cmp++; if (sel_b !== 3'd2) begin n_bad++; $display("FAIL ld_use_sel_b got=%0d exp=2", sel_b); end
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 6, 1, 1, 0); tick();  // LOAD r6, reader does not use r6
    drive(1, 6, 6, 0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ld_unused_stall got=%b exp=0", stall); end
    idle(3);
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 0, 2, 1, 1, 0); tick();
    drive(1, 2, 2, 1, 1, 0, 7, 1, 0, 1);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ex_valid got=%b exp=0", ex_valid); end
    n_cmp++; if (sel_a !== 3'd0) begin n_bad++; $display("FAIL flush_sel_a got=%0d exp=0", sel_a); end
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_bad++; $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
    idle(3);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0, 0, 0, 2, 1, 1, 0); tick();
      drive(1, 2, 0, 1, 0, 0, 1, 0, 0, 0); tick();
      if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      tick();
    end
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_bad++; $display("FAIL sat_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
    n_cmp++; if (stall_cnt !== 3'd7) begin n_bad++; $display("FAIL sat_all_ones got=%0d exp=7", stall_cnt); end
    idle(3);
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0, 4, 1, 1, 0); tick();  // LOAD r4
    drive(1, 4, 0, 1, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_stall got=%b exp=1", stall); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = '0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rmid_stall got=%b exp=0", stall); end
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_bad++; $display("FAIL rmid_cnt got=%0d exp=0", stall_cnt); end
    tick();
    n_cmp++; if (sel_a !== 3'd0) begin n_bad++; $display("FAIL rmid_sel_a got=%0d exp=0", sel_a); end
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_ex_valid got=%b exp=1", ex_valid); end
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0;
    exp_cnt = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_fwd_distance();
    test_priority();
    test_load_use();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
